// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction width, IMemory geometry
// and the state encoding of the instruction-memory loader.
package cpu_pkg;

    localparam int WORD_W      = 16;
    localparam int IMEM_ADDR_W = 10;

    localparam logic [2:0] LD_IDLE    = 3'd0;
    localparam logic [2:0] LD_LEN_HI  = 3'd1;
    localparam logic [2:0] LD_LEN_LO  = 3'd2;
    localparam logic [2:0] LD_DATA_HI = 3'd3;
    localparam logic [2:0] LD_DATA_LO = 3'd4;
    localparam logic [2:0] LD_CHECK   = 3'd5;
    localparam logic [2:0] LD_DONE    = 3'd6;
    localparam logic [2:0] LD_ERR     = 3'd7;

endpackage

// File: rtl/imem_load_cksum.sv
// Running XOR over the loader's LEN and DATA bytes; compares the
// accumulated value against the trailing checksum byte.
module imem_load_cksum (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       accum,
    input  logic [7:0] in_byte,
    output logic       match
);

    logic [7:0] sum;

    // accumulator: cleared at load start, folds in each accepted byte
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sum <= 8'h00;
        end else if (clear) begin
            sum <= 8'h00;
        end else if (accum) begin
            sum <= sum ^ in_byte;
        end
    end

    assign match = (sum == in_byte);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for IMemory; holds the CPU until done.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [15:0] MAX_N = 16'(1 << ADDR_W);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] END_ST = LD_CHECK;
`else
    localparam logic [2:0] END_ST = LD_DONE;
`endif

    logic [2:0]        state;
    logic [7:0]        len_hi;
    logic [7:0]        hi_byte;
    logic [15:0]       len;
    logic [ADDR_W-1:0] k;
    logic              accept;
    logic              idle_like;
    logic [15:0]       len_new;
    logic              last_word;

    assign in_ready = (state == LD_LEN_HI) || (state == LD_LEN_LO)
                   || (state == LD_DATA_HI) || (state == LD_DATA_LO)
`ifdef IMEM_LOADER_CHECKSUM_EN
                   || (state == LD_CHECK)
`endif
                   ;

    assign accept    = in_valid & in_ready;
    assign idle_like = (state == LD_IDLE) || (state == LD_DONE)
                    || (state == LD_ERR);
    assign len_new   = {len_hi, in_byte};
    assign last_word = (16'(k) == (len - 16'd1));

    assign done     = (state == LD_DONE);
    assign error    = (state == LD_ERR);
    assign cpu_hold = (state != LD_DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic cksum_ok;

    imem_load_cksum u_cksum (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start & idle_like),
        .accum   (accept & (state != LD_CHECK)),
        .in_byte (in_byte),
        .match   (cksum_ok)
    );
`endif

    // load sequencer; the write port is registered one cycle after LO
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= LD_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            len_hi    <= 8'h00;
            hi_byte   <= 8'h00;
            len       <= 16'h0000;
            k         <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                LD_IDLE, LD_DONE, LD_ERR: begin
                    if (start) begin
                        state <= LD_LEN_HI;
                        k     <= '0;
                    end
                end
                LD_LEN_HI: begin
                    if (accept) begin
                        len_hi <= in_byte;
                        state  <= LD_LEN_LO;
                    end
                end
                LD_LEN_LO: begin
                    if (accept) begin
                        len <= len_new;
                        if (len_new == 16'h0000) begin
                            state <= END_ST;
                        end else if (len_new > MAX_N) begin
                            state <= LD_ERR;
                        end else begin
                            state <= LD_DATA_HI;
                        end
                    end
                end
                LD_DATA_HI: begin
                    if (accept) begin
                        hi_byte <= in_byte;
                        state   <= LD_DATA_LO;
                    end
                end
                LD_DATA_LO: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= k;
                        mem_wdata <= {hi_byte, in_byte};
                        k         <= k + 1'b1;
                        state     <= last_word ? END_ST : LD_DATA_HI;
                    end
                end
                LD_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept) begin
                        state <= cksum_ok ? LD_DONE : LD_ERR;
                    end
`else
                    state <= LD_ERR;
`endif
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams programs, records
// IMemory writes and checks them against hand-written tables.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int total = 0;
    int bad = 0;
    int consec = 0;
    logic prev_we = 1'b0;
    bit gaps = 1'b0;
    logic [7:0] ck = 8'h00;

    logic [9:0]  wa[$];
    logic [15:0] wd[$];
    logic        wdone[$];
    logic        whold[$];

    logic [15:0] prog [8];

    always #5 clock = ~clock;

    imem_loader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    // write monitor
    always @(negedge clock) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wdone.push_back(done);
            whold.push_back(cpu_hold);
            if (prev_we) consec++;
        end
        prev_we = mem_we;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        wa.delete();
        wd.delete();
        wdone.delete();
        whold.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        ck = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gaps && ($urandom_range(1) == 1)) begin
            in_valid = 1'b0;
            @(negedge clock);
        end
        in_byte = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        @(negedge clock);
        in_valid = 1'b0;
        ck = ck ^ b;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic send_ck();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = ck;
        send_byte(c);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        prog[0] = 16'h5101;
        prog[1] = 16'h5202;
        prog[2] = 16'h0650;
        prog[3] = 16'h0A71;
        prog[4] = 16'h0C52;
        prog[5] = 16'h0E93;
        prog[6] = 16'h0FB4;
        prog[7] = 16'h400F;

        // reset
        idle(3);
        chk("rst_ready", in_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset_n = 1'b1;
        idle(1);

        // T1: 8-word program
        clr();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h08);
        for (int i = 0; i < 8; i++) send_word(prog[i]);
        send_ck();
        idle(2);
        chk("t1_nwr", wa.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < wa.size()) begin
                chk($sformatf("t1_addr%0d", i), wa[i], i);
                chk($sformatf("t1_data%0d", i), wd[i], prog[i]);
            end
        end
        if (wa.size() == 8) begin
            chk("t1_hold_mid", whold[6], 1);
            chk("t1_done_last", wdone[7], CK ? 0 : 1);
            chk("t1_hold_last", whold[7], CK ? 1 : 0);
        end
        chk("t1_done", done, 1);
        chk("t1_hold", cpu_hold, 0);
        chk("t1_error", error, 0);

        // T2: empty image
        clr();
        pulse_start();
        chk("t2_done_clr", done, 0);
        chk("t2_hold_set", cpu_hold, 1);
        send_byte(8'h00);
        send_byte(8'h00);
        send_ck();
        chk("t2_done", done, 1);
        chk("t2_hold", cpu_hold, 0);
        chk("t2_ready", in_ready, 0);
        idle(2);
        chk("t2_nwr", wa.size(), 0);

        // T3: oversize length, then a one-word reload
        clr();
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h01);
        chk("t3_error", error, 1);
        chk("t3_hold", cpu_hold, 1);
        chk("t3_done", done, 0);
        chk("t3_ready", in_ready, 0);
        idle(2);
        chk("t3_nwr", wa.size(), 0);
        pulse_start();
        chk("t3_err_clr", error, 0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(16'h400F);
        send_ck();
        idle(2);
        chk("t3_nwr2", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("t3_addr", wa[0], 0);
            chk("t3_data", wd[0], 16'h400F);
        end
        chk("t3_done2", done, 1);

        // T4: gaps in in_valid
        clr();
        gaps = 1'b1;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        for (int i = 0; i < 4; i++) send_word(prog[i]);
        send_ck();
        gaps = 1'b0;
        idle(2);
        chk("t4_nwr", wa.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wa.size()) begin
                chk($sformatf("t4_addr%0d", i), wa[i], i);
                chk($sformatf("t4_data%0d", i), wd[i], prog[i]);
            end
        end
        chk("t4_consec", consec, 0);
        chk("t4_done", done, 1);

        // T5: reset in the middle of word 2
        clr();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h08);
        send_word(prog[0]);
        send_word(prog[1]);
        send_byte(prog[2][15:8]);
        reset_n = 1'b0;
        idle(1);
        chk("t5_we", mem_we, 0);
        chk("t5_addr", mem_addr, 0);
        chk("t5_wdata", mem_wdata, 0);
        chk("t5_hold", cpu_hold, 1);
        chk("t5_done", done, 0);
        chk("t5_error", error, 0);
        chk("t5_ready", in_ready, 0);
        idle(2);
        chk("t5_nwr", wa.size(), 2);
        reset_n = 1'b1;
        idle(1);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(16'h1234);
        send_ck();
        idle(2);
        chk("t5_nwr2", wa.size(), 3);
        if (wa.size() == 3) begin
            chk("t5_addr2", wa[2], 0);
            chk("t5_data2", wd[2], 16'h1234);
        end
        chk("t5_done2", done, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // T6: explicit checksum values
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(16'h1234);
        send_byte(8'h27);
        chk("t6_done", done, 1);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(16'h1234);
        send_byte(8'h26);
        chk("t6_error", error, 1);
        chk("t6_hold", cpu_hold, 1);
`endif

        chk("all_consec", consec, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
